mcpu5_imem_driver: RTL and testbench

Program-memory responder for the MCPU5 core: holds a small instruction store, loads it through a valid/ready write port, and holds the core in reset while loading and during a short boot window. In RUN it returns the 6-bit instruction addressed by the program counter the core presents on its 8-bit output bus. It sits on the opposite side of the core's `{inst_in, reset, clk}` / `cpu_out` interface and replaces hand-driven instruction stimulus.

---
 rtl/mcpu5_imem_driver.sv | 118 +++++++++++
 tb/tb_mcpu5_imem_driver.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu5_imem_driver.sv
// Program-memory responder for the MCPU5 core: loads a small instruction store over a
// valid/ready port, holds the core in reset through load and boot, then serves fetches.
module mcpu5_imem_driver #(
    parameter int          ADDR_W      = 6,
    parameter int          BOOT_CYCLES = 2,
    parameter logic [5:0]  FILL_INST   = 6'b111001
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        cpu_out,
    output logic [5:0]        inst_in,
    output logic              cpu_reset,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [5:0]        ld_data,
    output logic              ld_ready,
    input  logic              ld_done,
    output logic [ADDR_W:0]   words_loaded,
    output logic              overflow,
    output logic              running
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_BOOT = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W:0]    r_wptr;
    logic [ADDR_W:0]    w_wptr_nxt;
    logic               r_ovf;
    logic               w_ovf_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [5:0]         r_mem [DEPTH];

    logic               w_full;
    logic               w_wr;
    logic [ADDR_W-1:0]  w_pc;
    logic               w_unused_cpu_out;

    assign w_full = r_wptr[ADDR_W];
    // ld_start pre-empts everything, including a write offered in the same cycle
    assign w_wr   = (r_state == S_LOAD) && !ld_start && ld_valid && !w_full;
    assign w_pc   = cpu_out[ADDR_W-1:0];
    assign w_unused_cpu_out = ^cpu_out[7:ADDR_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_wptr  <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wptr  <= w_wptr_nxt;
            r_ovf   <= w_ovf_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wptr_nxt  = r_wptr;
        w_ovf_nxt   = r_ovf;
        w_cnt_nxt   = r_cnt;
        if (ld_start) begin
            w_state_nxt = S_LOAD;
            w_wptr_nxt  = '0;
            w_ovf_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_wr)
                        w_wptr_nxt = r_wptr + (ADDR_W+1)'(1);
                    if (ld_valid && w_full)
                        w_ovf_nxt = 1'b1;
                    if (ld_done) begin
                        w_state_nxt = S_BOOT;
                        w_cnt_nxt   = CNT_W'(BOOT_CYCLES);
                    end
                end
                S_BOOT: begin
                    if (r_cnt <= CNT_W'(1))
                        w_state_nxt = S_RUN;
                    else
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Store contents survive reset; only the write pointer is cleared
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wptr[ADDR_W-1:0]] <= ld_data;
    end

    always_comb begin
        inst_in = FILL_INST;
        if ((r_state == S_RUN) && ({1'b0, w_pc} < r_wptr))
            inst_in = r_mem[w_pc];
    end

    assign cpu_reset    = (r_state != S_RUN);
    assign running      = (r_state == S_RUN);
    assign ld_ready     = (r_state == S_LOAD) && !w_full;
    assign words_loaded = r_wptr;
    assign overflow     = r_ovf;

endmodule

// File: tb/tb_mcpu5_imem_driver.sv
// Scoreboard bench for mcpu5_imem_driver: stimulus queues expected outputs, a monitor
// on the falling edge pops and compares them against the DUT.
module tb_mcpu5_imem_driver;

    localparam logic [5:0] FILL = 6'b111001;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] cpu_out;
    logic [5:0] inst_in;
    logic       cpu_reset;
    logic       ld_start;
    logic       ld_valid;
    logic [5:0] ld_data;
    logic       ld_ready;
    logic       ld_done;
    logic [6:0] words_loaded;
    logic       overflow;
    logic       running;

    mcpu5_imem_driver dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_out      (cpu_out),
        .inst_in      (inst_in),
        .cpu_reset    (cpu_reset),
        .ld_start     (ld_start),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .ld_ready     (ld_ready),
        .ld_done      (ld_done),
        .words_loaded (words_loaded),
        .overflow     (overflow),
        .running      (running)
    );

    always #5 clk = ~clk;

    typedef enum int {K_INST, K_CRST, K_RDY, K_WL, K_OVF, K_RUN} kind_t;
    typedef struct {
        kind_t kind;
        int    exp;
        string nm;
    } item_t;

    item_t q[$];
    int n_checks = 0;
    int n_errors = 0;

    function automatic int actual(kind_t k);
        case (k)
            K_INST:  return int'(inst_in);
            K_CRST:  return int'(cpu_reset);
            K_RDY:   return int'(ld_ready);
            K_WL:    return int'(words_loaded);
            K_OVF:   return int'(overflow);
            default: return int'(running);
        endcase
    endfunction

    // Monitor: drain every queued expectation against the outputs mid-cycle
    always @(negedge clk) begin
        while (q.size() > 0) begin
            item_t it;
            int    act;
            it  = q.pop_front();
            act = actual(it.kind);
            n_checks++;
            if (act !== it.exp) begin
                n_errors++;
                $display("FAIL %s: got %0d expected %0d at %0t", it.nm, act, it.exp, $time);
            end
        end
    end

    task automatic expect_v(kind_t k, int v, string nm);
        item_t it;
        it.kind = k;
        it.exp  = v;
        it.nm   = nm;
        q.push_back(it);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_reset_vals(string tag);
        expect_v(K_CRST, 1, {tag, "_cpu_reset"});
        expect_v(K_RDY,  0, {tag, "_ld_ready"});
        expect_v(K_WL,   0, {tag, "_words_loaded"});
        expect_v(K_OVF,  0, {tag, "_overflow"});
        expect_v(K_RUN,  0, {tag, "_running"});
        expect_v(K_INST, int'(FILL), {tag, "_inst_in"});
    endtask

    task automatic pulse_start();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    // ld_done then two boot cycles brings the core out of reset
    task automatic done_and_boot();
        ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
        expect_v(K_CRST, 1, "boot1_cpu_reset");
        tick();
        expect_v(K_CRST, 1, "boot2_cpu_reset");
        tick();
        expect_v(K_CRST, 0, "run_cpu_reset");
        expect_v(K_RUN,  1, "run_running");
        expect_v(K_RDY,  0, "run_ld_ready");
    endtask

    task automatic fetch(logic [7:0] addr, logic [5:0] exp, string nm);
        cpu_out = addr;
        expect_v(K_INST, int'(exp), nm);
        tick();
    endtask

    logic [5:0] words15 [15] = '{6'b010001, 6'b011110, 6'b101001, 6'b111000, 6'b101010,
                                 6'b010000, 6'b100001, 6'b100010, 6'b100001, 6'b000010,
                                 6'b001111, 6'b010001, 6'b111010, 6'b100111, 6'b001100};

    initial begin
        reset_n  = 1'b0;
        cpu_out  = 8'h00;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 6'h00;
        ld_done  = 1'b0;
        tick();
        expect_reset_vals("por");
        tick();
        reset_n = 1'b1;
        tick();

        // 15-word program
        pulse_start();
        expect_v(K_RDY, 1, "load_ld_ready");
        expect_v(K_CRST, 1, "load_cpu_reset");
        for (int i = 0; i < 15; i++) begin
            ld_valid = 1'b1;
            ld_data  = words15[i];
            tick();
        end
        ld_valid = 1'b0;
        expect_v(K_WL, 15, "p15_words_loaded");
        tick();
        done_and_boot();
        for (int i = 0; i < 15; i++)
            fetch(8'(i), words15[i], "p15_fetch");
        fetch(8'd15, FILL, "p15_unloaded");

        // Full store plus one extra word
        pulse_start();
        for (int i = 0; i < 64; i++) begin
            ld_valid = 1'b1;
            ld_data  = 6'(i) ^ 6'h2A;
            tick();
        end
        expect_v(K_RDY, 0, "full_ld_ready");
        expect_v(K_WL, 64, "full_words_loaded");
        expect_v(K_OVF, 0, "full_no_ovf_yet");
        tick();
        ld_valid = 1'b0;
        expect_v(K_OVF, 1, "full_overflow");
        expect_v(K_WL, 64, "full_words_kept");
        tick();
        done_and_boot();
        fetch(8'hC3, 6'h29, "wrap_c3");
        fetch(8'hFF, 6'h15, "wrap_ff");
        fetch(8'h40, 6'h2A, "wrap_40");
        expect_v(K_OVF, 1, "run_overflow_sticky");
        tick();

        // Gapped writes, ld_done alongside the third
        pulse_start();
        expect_v(K_OVF, 0, "start_clears_ovf");
        ld_valid = 1'b1; ld_data = 6'h05; tick();
        ld_valid = 1'b0; tick();
        ld_valid = 1'b1; ld_data = 6'h0A; tick();
        ld_valid = 1'b0; tick();
        tick();
        ld_valid = 1'b1; ld_data = 6'h33; ld_done = 1'b1;
        tick();
        ld_valid = 1'b0; ld_done = 1'b0;
        expect_v(K_WL, 3, "gap_words_loaded");
        expect_v(K_RDY, 0, "gap_boot_ld_ready");
        tick();
        tick();
        expect_v(K_RUN, 1, "gap_running");
        fetch(8'd2, 6'h33, "gap_third_word");
        fetch(8'd1, 6'h0A, "gap_second_word");
        fetch(8'd3, FILL, "gap_beyond_loaded");

        // ld_start and ld_done together while running
        cpu_out  = 8'd2;
        ld_start = 1'b1;
        ld_done  = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_done  = 1'b0;
        expect_v(K_CRST, 1, "both_cpu_reset");
        expect_v(K_WL, 0, "both_words_loaded");
        expect_v(K_INST, int'(FILL), "both_inst_in");
        expect_v(K_RDY, 1, "both_ld_ready");
        expect_v(K_RUN, 0, "both_running");
        tick();

        // Asynchronous reset during BOOT
        ld_valid = 1'b1; ld_data = 6'h11; tick();
        ld_valid = 1'b0; ld_done = 1'b1; tick();
        ld_done  = 1'b0;
        expect_v(K_WL, 1, "boot_words_loaded");
        tick();
        reset_n = 1'b0;
        #1;
        expect_reset_vals("async");
        tick();
        reset_n = 1'b1;
        tick();

        // ld_done in IDLE must not start a boot
        ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
        tick();
        tick();
        tick();
        expect_v(K_CRST, 1, "idle_done_cpu_reset");
        expect_v(K_RUN, 0, "idle_done_running");
        expect_v(K_RDY, 0, "idle_done_ld_ready");
        tick();

        // Zero-word load
        pulse_start();
        done_and_boot();
        expect_v(K_WL, 0, "zero_words_loaded");
        fetch(8'd0, FILL, "zero_fetch0");
        fetch(8'd5, FILL, "zero_fetch5");
        fetch(8'd63, FILL, "zero_fetch63");

        tick();
        tick();
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
